m8b_32: RTL
===========

M8B_32 -- requirements
Module: m8b_32

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the completed-word counter.
REQ-002 The block SHALL have port clk_4f, input, 1 bit: the single clock, rising-edge active, at the byte rate.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port data_8, input, 8 bits: the byte stream from the lane.
REQ-005 The block SHALL have port valid_8, input, 1 bit: data_8 is valid on the current clk_4f edge.
REQ-006 The block SHALL have port data_8_32, output, 32 bits: the reassembled word, with the first byte in [31:24].
REQ-007 The block SHALL have port valid_8_32, output, 1 bit: a 1-cycle pulse marking a newly completed word on data_8_32.
REQ-008 The block SHALL have port err_partial, output, 1 bit: a 1-cycle pulse when a word is abandoned before completion.
REQ-009 The block SHALL have port word_cnt, output, CNT_W bits: the count of completed words since reset.

Function
REQ-010 Byte order SHALL be MSB-first: valid bytes 0,1,2,3 of a word go to data_8_32 [31:24], [23:16], [15:8], [7:0].
REQ-011 The FSM SHALL have states IDLE, B1, B2 and B3, where Bn means n bytes of the current word are held in the shift register.
REQ-012 IDLE with valid_8=1 SHALL capture data_8 into shift[31:24] and go to B1.
REQ-013 B1 with valid_8=1 SHALL capture data_8 into [23:16] and go to B2.
REQ-014 B2 with valid_8=1 SHALL capture data_8 into [15:8] and go to B3.
REQ-015 B3 with valid_8=1 SHALL load {shift[31:8], data_8} into data_8_32 on that same edge, assert valid_8_32 for exactly that one cycle, increment word_cnt, and go to IDLE.
REQ-016 Word framing SHALL restart at the first valid byte following any cycle with valid_8=0, matching the transmit-side selector clear on valid deassertion.
REQ-017 valid_8=0 in B1, B2 or B3 SHALL discard the partial word, pulse err_partial for 1 cycle, and go to IDLE.
REQ-018 The abandonment in REQ-017 SHALL leave data_8_32, valid_8_32 and word_cnt unchanged.
REQ-019 valid_8=0 in IDLE SHALL hold IDLE with no err_partial pulse.
REQ-020 Latency SHALL be 1 clk_4f edge: data_8_32 and valid_8_32 are registered and visible immediately after the edge sampling byte 3.
REQ-021 data_8_32 SHALL hold the last completed word until the next completion.
REQ-022 valid_8_32 and err_partial SHALL never be asserted in the same cycle.
REQ-023 word_cnt SHALL wrap modulo 2^CNT_W without saturation or flag, e.g. CNT_W=8 gives 8'hFF to 8'h00.
REQ-024 Back-to-back words with valid_8 continuously high SHALL produce one valid_8_32 pulse every 4 cycles with no idle cycle required.
REQ-025 The shift register SHALL not be cleared on completion; stale upper bytes SHALL be overwritten by subsequent captures.
REQ-026 No combinational path SHALL exist from any input to any output.

Reset
REQ-027 reset=0 SHALL, asynchronously, force the FSM to IDLE, the shift register to 32'h0, data_8_32 to 32'h0, valid_8_32 to 0, err_partial to 0 and word_cnt to 0.
REQ-028 reset asserted mid-word SHALL drop the partial word without an err_partial pulse.
REQ-029 After reset deasserts, the first edge with valid_8=1 SHALL be treated as byte 0.

Verification
REQ-030 The bench SHALL cover: reset, then bytes BC,1C,5A,A5 with valid_8=1 -> data_8_32=32'hBC1C5AA5 and valid_8_32=1 on cycle 4 only, word_cnt=1.
REQ-031 The bench SHALL cover: 12 continuous bytes 00..0B -> pulses on cycles 4, 8 and 12 with data 00010203, 04050607 and 08090A0B, word_cnt=3.
REQ-032 The bench SHALL cover: bytes 11,22 then valid_8=0 -> err_partial pulse, data_8_32 unchanged; next bytes 33,44,55,66 -> 32'h33445566.
REQ-033 The bench SHALL cover: reset pulsed low asynchronously between clock edges after 2 bytes -> all outputs 0 immediately, no err_partial, next 4 bytes form a full word.
REQ-034 The bench SHALL cover: 256 words with CNT_W=8 -> word_cnt returns to 8'h00.
REQ-035 The bench SHALL cover: the m32b_8 output looped into m8b_32 with random 32-bit words, each presented for 4 clk_4f cycles -> every word reproduced exactly in order.

Source files
------------

// File: rtl/m8b_32.sv
// Byte-to-word deframer: packs four MSB-first valid bytes into a 32-bit word, pulsing valid_8_32 on completion.
// Latency 1 clk_4f edge after byte 3; no backpressure: a valid_8 gap abandons the partial word with err_partial.
module m8b_32 #(
   parameter int CNT_W = 8
) (
   input  logic             clk_4f,
   input  logic             reset,
   input  logic [7:0]       data_8,
   input  logic             valid_8,
   output logic [31:0]      data_8_32,
   output logic             valid_8_32,
   output logic             err_partial,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

   state_t           state_q, state_d;
   logic [31:0]      shift_q, shift_d;
   logic [31:0]      data_q, data_d;
   logic             vld_q, vld_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_8) begin
               shift_d[31:24] = data_8;
               state_d        = B1;
            end
         end
         B1: begin
            if (valid_8) begin
               shift_d[23:16] = data_8;
               state_d        = B2;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         B2: begin
            if (valid_8) begin
               shift_d[15:8] = data_8;
               state_d       = B3;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         B3: begin
            // Final byte bypasses the shift register so the word lands on this edge.
            if (valid_8) begin
               data_d  = {shift_q[31:8], data_8};
               vld_d   = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= 32'h0;
         data_q  <= 32'h0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign data_8_32   = data_q;
   assign valid_8_32  = vld_q;
   assign err_partial = err_q;
   assign word_cnt    = cnt_q;

endmodule
